// File: rtl/tlc_pkg.sv
// Shared definitions for the intersection-controller front end.
// Holds the debouncer state encoding, the default timing constants and a
// small state-decode helper used by the sensor conditioner and the controller.
package tlc_pkg;

    // Debouncer states: two settled levels plus one qualifying state per direction.
    typedef enum logic [1:0] {
        LOW      = 2'd0,
        RISE_CHK = 2'd1,
        HIGH     = 2'd2,
        FALL_CHK = 2'd3
    } db_state_t;

    localparam int unsigned DEF_DEBOUNCE_CYCLES = 32'd16;
    localparam int unsigned DEF_STUCK_CYCLES    = 32'd60000;
    localparam int unsigned DEF_TWIDTH          = 32'd16;
    localparam int unsigned DEF_CNT_WIDTH       = 32'd8;

    // True in the states where the accepted (debounced) level is high.
    function automatic logic is_high_side(input db_state_t st);
        return (st == HIGH) || (st == FALL_CHK);
    endfunction

endpackage

// File: rtl/tlc_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input.
// Ports:
//   clk  - sampling clock
//   rst  - synchronous active-high reset, clears both flops to 0
//   d    - asynchronous input level
//   q    - synchronised level, two rising edges after d is sampled
module tlc_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // Metastability-settling chain; the first flop is never used directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/traffic_sensor_conditioner.sv
// Vehicle-loop sensor conditioner for the intersection controller.
// Synchronises and debounces the raw loop level, counts arrivals, keeps a
// latched demand request cleared by a req/ack handshake, and forces demand
// on when the loop has been accepted-high for too long (stuck loop).
// Ports:
//   clk           - single clock, all state on rising edge
//   rst           - synchronous active-high reset
//   sensor_raw    - asynchronous loop-detector level
//   demand_ack    - controller pulse: pending demand has been served
//   count_clear   - synchronous clear of vehicle_count
//   sensor_clean  - debounced presence level
//   demand_req    - latched service request (also held high while stuck)
//   vehicle_count - saturating arrival counter
//   stuck_fault   - loop stuck-high flag
module traffic_sensor_conditioner
    import tlc_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned STUCK_CYCLES    = DEF_STUCK_CYCLES,
    parameter int unsigned TWIDTH          = DEF_TWIDTH,
    parameter int unsigned CNT_WIDTH       = DEF_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sensor_raw,
    input  logic                 demand_ack,
    input  logic                 count_clear,
    output logic                 sensor_clean,
    output logic                 demand_req,
    output logic [CNT_WIDTH-1:0] vehicle_count,
    output logic                 stuck_fault
);

    // Terminal timer values, truncated to the timer width.
    localparam logic [TWIDTH-1:0]    DB_LAST    = TWIDTH'(DEBOUNCE_CYCLES - 32'd1);
    localparam logic [TWIDTH-1:0]    STUCK_LAST = TWIDTH'(STUCK_CYCLES - 32'd1);
    localparam logic [TWIDTH-1:0]    T_ZERO     = TWIDTH'(1'b0);
    localparam logic [TWIDTH-1:0]    T_ONE      = TWIDTH'(1'b1);
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO   = CNT_WIDTH'(1'b0);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1'b1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX    = {CNT_WIDTH{1'b1}};

    logic                 sync_s;
    db_state_t            state_r;
    db_state_t            state_s;
    logic [TWIDTH-1:0]    db_timer_r;
    logic [TWIDTH-1:0]    db_timer_s;
    logic                 arrival_s;
    logic [TWIDTH-1:0]    stuck_timer_r;
    logic [TWIDTH-1:0]    stuck_timer_s;
    logic                 stuck_fault_r;
    logic                 stuck_fault_s;
    logic                 demand_latch_r;
    logic                 demand_latch_s;
    logic [CNT_WIDTH-1:0] count_r;
    logic [CNT_WIDTH-1:0] count_s;
    logic                 clean_r;
    logic                 clean_s;
    logic                 demand_req_r;
    logic                 demand_req_s;

    tlc_sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d   (sensor_raw),
        .q   (sync_s)
    );

    // Debouncer state and debounce timer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= LOW;
            db_timer_r <= T_ZERO;
        end else begin
            state_r    <= state_s;
            db_timer_r <= db_timer_s;
        end
    end

    // Debouncer next state; the arrival strobe marks RISE_CHK -> HIGH.
    always_comb begin
        state_s    = state_r;
        db_timer_s = db_timer_r;
        arrival_s  = 1'b0;
        case (state_r)
            LOW: begin
                if (sync_s) begin
                    state_s    = RISE_CHK;
                    db_timer_s = T_ZERO;
                end else begin
                    state_s    = LOW;
                end
            end
            RISE_CHK: begin
                if (!sync_s) begin
                    state_s = LOW;
                end else if (db_timer_r == DB_LAST) begin
                    state_s   = HIGH;
                    arrival_s = 1'b1;
                end else begin
                    db_timer_s = db_timer_r + T_ONE;
                end
            end
            HIGH: begin
                if (!sync_s) begin
                    state_s    = FALL_CHK;
                    db_timer_s = T_ZERO;
                end else begin
                    state_s    = HIGH;
                end
            end
            FALL_CHK: begin
                if (sync_s) begin
                    state_s = HIGH;
                end else if (db_timer_r == DB_LAST) begin
                    state_s = LOW;
                end else begin
                    db_timer_s = db_timer_r + T_ONE;
                end
            end
            default: begin
                state_s    = LOW;
                db_timer_s = T_ZERO;
            end
        endcase
    end

    // Next values of the stuck monitor, counter, demand latch and outputs.
    always_comb begin
        clean_s = is_high_side(state_s);

        // Stuck timer runs through FALL_CHK bounces and only restarts in LOW;
        // once the fault is raised the timer simply holds.
        stuck_timer_s = stuck_timer_r;
        stuck_fault_s = stuck_fault_r;
        if (state_s == LOW) begin
            stuck_timer_s = T_ZERO;
            stuck_fault_s = 1'b0;
        end else if (is_high_side(state_r) && !stuck_fault_r) begin
            if (stuck_timer_r == STUCK_LAST) begin
                stuck_fault_s = 1'b1;
            end else begin
                stuck_timer_s = stuck_timer_r + T_ONE;
            end
        end else begin
            stuck_timer_s = stuck_timer_r;
        end

        // A clear coincident with an arrival leaves exactly that arrival counted.
        if (count_clear) begin
            count_s = arrival_s ? CNT_ONE : CNT_ZERO;
        end else if (arrival_s && (count_r != CNT_MAX)) begin
            count_s = count_r + CNT_ONE;
        end else begin
            count_s = count_r;
        end

        // A new arrival outranks an acknowledge in the same cycle.
        if (arrival_s) begin
            demand_latch_s = 1'b1;
        end else if (demand_ack) begin
            demand_latch_s = 1'b0;
        end else begin
            demand_latch_s = demand_latch_r;
        end

        demand_req_s = demand_latch_s | stuck_fault_s;
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            stuck_timer_r  <= T_ZERO;
            stuck_fault_r  <= 1'b0;
            count_r        <= CNT_ZERO;
            demand_latch_r <= 1'b0;
            clean_r        <= 1'b0;
            demand_req_r   <= 1'b0;
        end else begin
            stuck_timer_r  <= stuck_timer_s;
            stuck_fault_r  <= stuck_fault_s;
            count_r        <= count_s;
            demand_latch_r <= demand_latch_s;
            clean_r        <= clean_s;
            demand_req_r   <= demand_req_s;
        end
    end

    assign sensor_clean  = clean_r;
    assign demand_req    = demand_req_r;
    assign vehicle_count = count_r;
    assign stuck_fault   = stuck_fault_r;

endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// Directed bench for traffic_sensor_conditioner with DEBOUNCE_CYCLES=4,
// STUCK_CYCLES=20, CNT_WIDTH=3. Expected values are hand-derived edge counts:
// with the raw level first sampled at edge 1, the debounced level changes
// after edge 7 in either direction.
module tb_traffic_sensor_conditioner;

    logic       clk = 1'b0;
    logic       rst;
    logic       sensor_raw;
    logic       demand_ack;
    logic       count_clear;
    logic       sensor_clean;
    logic       demand_req;
    logic [2:0] vehicle_count;
    logic       stuck_fault;

    int vectors     = 0;
    int miscompares = 0;

    traffic_sensor_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .STUCK_CYCLES    (20),
        .TWIDTH          (16),
        .CNT_WIDTH       (3)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .sensor_raw    (sensor_raw),
        .demand_ack    (demand_ack),
        .count_clear   (count_clear),
        .sensor_clean  (sensor_clean),
        .demand_req    (demand_req),
        .vehicle_count (vehicle_count),
        .stuck_fault   (stuck_fault)
    );

    always #5 clk = ~clk;

    // One rising edge, then settle so outputs are sampled away from the edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst         = 1'b1;
        sensor_raw  = 1'b0;
        demand_ack  = 1'b0;
        count_clear = 1'b0;
        tick(2);
        rst = 1'b0;
        check("reset_clean", 32'(sensor_clean), 32'd0);
        check("reset_req", 32'(demand_req), 32'd0);
        check("reset_count", 32'(vehicle_count), 32'd0);
        check("reset_fault", 32'(stuck_fault), 32'd0);

        // Clean rise: accepted after edge 7, one arrival, demand latched.
        sensor_raw = 1'b1;
        tick(6);
        check("rise_edge6_clean", 32'(sensor_clean), 32'd0);
        check("rise_edge6_count", 32'(vehicle_count), 32'd0);
        tick(1);
        check("rise_edge7_clean", 32'(sensor_clean), 32'd1);
        check("rise_edge7_count", 32'(vehicle_count), 32'd1);
        check("rise_edge7_req", 32'(demand_req), 32'd1);
        // Symmetric fall latency.
        sensor_raw = 1'b0;
        tick(6);
        check("fall_edge6_clean", 32'(sensor_clean), 32'd1);
        tick(1);
        check("fall_edge7_clean", 32'(sensor_clean), 32'd0);

        // Single-cycle acknowledge clears the demand.
        demand_ack = 1'b1;
        tick(1);
        demand_ack = 1'b0;
        check("ack_clears_req", 32'(demand_req), 32'd0);

        // Arrival on the ack cycle wins.
        sensor_raw = 1'b1;
        tick(6);
        check("pre_arrival_req", 32'(demand_req), 32'd0);
        demand_ack = 1'b1;
        tick(1);
        demand_ack = 1'b0;
        check("arrival_ack_req", 32'(demand_req), 32'd1);
        check("arrival_ack_count", 32'(vehicle_count), 32'd2);
        demand_ack = 1'b1;
        tick(1);
        demand_ack = 1'b0;
        check("ack2_clears_req", 32'(demand_req), 32'd0);
        sensor_raw = 1'b0;
        tick(7);
        check("fall2_clean", 32'(sensor_clean), 32'd0);

        // Short pulse (3 cycles) is rejected.
        sensor_raw = 1'b1;
        tick(3);
        sensor_raw = 1'b0;
        tick(10);
        check("glitch_clean", 32'(sensor_clean), 32'd0);
        check("glitch_req", 32'(demand_req), 32'd0);
        check("glitch_count", 32'(vehicle_count), 32'd2);

        // Clear alone.
        count_clear = 1'b1;
        tick(1);
        count_clear = 1'b0;
        check("clear_count", 32'(vehicle_count), 32'd0);

        // Nine arrivals saturate the 3-bit counter at 7.
        for (int i = 1; i <= 9; i++) begin
            sensor_raw = 1'b1;
            tick(6);
            sensor_raw = 1'b0;
            tick(8);
            check($sformatf("sat_count_%0d", i), 32'(vehicle_count), (i < 7) ? 32'(i) : 32'd7);
        end
        check("sat_req", 32'(demand_req), 32'd1);

        // Clear coincident with an arrival leaves 1.
        sensor_raw = 1'b1;
        tick(6);
        sensor_raw  = 1'b0;
        count_clear = 1'b1;
        tick(1);
        count_clear = 1'b0;
        check("clear_with_arrival", 32'(vehicle_count), 32'd1);
        tick(7);

        // Stuck-high loop with a 2-cycle glitch after acceptance.
        demand_ack = 1'b1;
        tick(1);
        demand_ack = 1'b0;
        check("pre_stuck_req", 32'(demand_req), 32'd0);
        sensor_raw = 1'b1;
        tick(7);
        check("stuck_accept_clean", 32'(sensor_clean), 32'd1);
        tick(2);
        sensor_raw = 1'b0;
        tick(2);
        sensor_raw = 1'b1;
        tick(2);
        check("bounce_clean", 32'(sensor_clean), 32'd1);
        tick(13);
        check("stuck_edge26_fault", 32'(stuck_fault), 32'd0);
        tick(1);
        check("stuck_edge27_fault", 32'(stuck_fault), 32'd1);
        check("stuck_edge27_req", 32'(demand_req), 32'd1);
        demand_ack = 1'b1;
        tick(1);
        demand_ack = 1'b0;
        check("stuck_ack_req", 32'(demand_req), 32'd1);
        check("stuck_ack_fault", 32'(stuck_fault), 32'd1);
        sensor_raw = 1'b0;
        tick(6);
        check("stuck_release6_fault", 32'(stuck_fault), 32'd1);
        tick(1);
        check("stuck_release7_fault", 32'(stuck_fault), 32'd0);
        check("stuck_release7_req", 32'(demand_req), 32'd0);
        check("stuck_release7_clean", 32'(sensor_clean), 32'd0);

        // Reset during RISE_CHK aborts the debounce; next pulse takes full latency.
        sensor_raw = 1'b1;
        tick(4);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("midrst_clean", 32'(sensor_clean), 32'd0);
        check("midrst_req", 32'(demand_req), 32'd0);
        check("midrst_count", 32'(vehicle_count), 32'd0);
        check("midrst_fault", 32'(stuck_fault), 32'd0);
        tick(6);
        check("postrst_edge6_clean", 32'(sensor_clean), 32'd0);
        check("postrst_edge6_count", 32'(vehicle_count), 32'd0);
        tick(1);
        check("postrst_edge7_clean", 32'(sensor_clean), 32'd1);
        check("postrst_edge7_count", 32'(vehicle_count), 32'd1);
        check("postrst_edge7_req", 32'(demand_req), 32'd1);
        sensor_raw = 1'b0;
        tick(7);
        check("postrst_fall_clean", 32'(sensor_clean), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/traffic_sensor_conditioner.md
Name: traffic_sensor_conditioner

Overview:
Upstream stage for the intersection controller. It conditions the raw vehicle-loop sensor by synchronising and debouncing it. It counts vehicle arrivals and presents a latched demand request to the controller, which clears it through a req/ack handshake. It also detects a stuck-high loop and fails safe by holding demand asserted.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive stable synchronised samples needed to accept a level change; must be >= 1
STUCK_CYCLES, 60000, cycles of continuous accepted-high after which the loop is declared stuck
TWIDTH, 16, width of the debounce/stuck timer; must hold STUCK_CYCLES-1 and DEBOUNCE_CYCLES-1
CNT_WIDTH, 8, width of the vehicle arrival counter

Ports:
clk  input  1  single clock, all state rising-edge
rst  input  1  synchronous, active-high reset
sensor_raw  input  1  asynchronous loop-detector level
demand_ack  input  1  controller pulse: demand has been served
count_clear  input  1  synchronous clear of vehicle_count
sensor_clean  output  1  debounced presence level
demand_req  output  1  latched service request to controller
vehicle_count  output  CNT_WIDTH  saturating arrival count
stuck_fault  output  1  loop stuck-high flag

Behaviour:
- Reset: the synchroniser flops, FSM, timers and all outputs are 0, and the FSM is in LOW. A reset mid-operation aborts any debounce in progress with no residual pulse.
- Synchroniser: two flops; s is the second-flop output. Raw-to-s latency is 2 edges.
- FSM states:
  - LOW: s=1 -> RISE_CHK with timer=0.
  - RISE_CHK: s=0 -> LOW. When s=1 and timer==DEBOUNCE_CYCLES-1 -> HIGH. Otherwise timer+1.
  - HIGH: s=0 -> FALL_CHK with db timer=0.
  - FALL_CHK: s=1 -> HIGH. When s=0 and timer==DEBOUNCE_CYCLES-1 -> LOW. Otherwise timer+1.
- sensor_clean = 1 in HIGH or FALL_CHK.
- Rise latency: count the first edge that samples sensor_raw=1 as edge 1. sensor_clean rises after edge DEBOUNCE_CYCLES+3. Fall latency is symmetric.
- Arrival event: a single-cycle internal strobe on the RISE_CHK->HIGH transition.
  - vehicle_count increments by 1 and saturates at all-ones; it never wraps.
  - The demand latch is set.
- count_clear: vehicle_count <= 0. If count_clear and an arrival occur in the same cycle, vehicle_count <= 1.
- Handshake:
  - The demand latch clears on the edge that samples demand_ack=1.
  - demand_ack with the latch at 0 is ignored.
  - An arrival and demand_ack in the same cycle leave the latch at 1 (arrival wins).
- Stuck detection:
  - A separate stuck timer (TWIDTH bits) counts every cycle in HIGH or FALL_CHK.
  - A FALL_CHK->HIGH bounce does not reset it; entering LOW resets it to 0.
  - When the stuck timer reaches STUCK_CYCLES-1, stuck_fault <= 1. It stays 1 until the FSM enters LOW or rst.
  - The stuck timer saturates once stuck_fault is set.
- demand_req = demand latch OR stuck_fault. While stuck, demand_ack clears the latch but demand_req stays 1.
- Width rule: all timer comparisons are unsigned at TWIDTH bits; parameters are truncated to TWIDTH.

Decomposition:
- Shared package tlc_pkg: the debouncer state encoding (LOW, RISE_CHK, HIGH, FALL_CHK, 2-bit) and the default timing constants, shared with the controller.
- Sub-module tlc_sync2: two-flop synchroniser with synchronous reset to 0, reused for any other asynchronous controller inputs.

Test Plan:
- DEBOUNCE_CYCLES=4, sensor_raw held 1 from edge 1 -> sensor_clean=1 after edge 7; vehicle_count 0->1; demand_req=1.
- sensor_raw high for 3 cycles (less than DEBOUNCE_CYCLES=4), then low -> sensor_clean, demand_req and vehicle_count all stay 0.
- demand_req=1, single-cycle demand_ack -> demand_req=0 next cycle. Repeat with a new arrival on the ack cycle -> demand_req stays 1 and count increments.
- CNT_WIDTH=3, 9 clean arrivals -> vehicle_count saturates at 7. Then count_clear coincident with an arrival -> vehicle_count=1.
- STUCK_CYCLES=20, sensor_raw held 1, with one 2-cycle low glitch after acceptance -> stuck_fault=1 at the 20th accepted-high cycle. demand_req stays 1 despite demand_ack; stuck_fault clears once sensor_raw is low long enough for the FSM to reach LOW.
- rst asserted during RISE_CHK -> all outputs 0 next cycle. A subsequent clean pulse follows the full DEBOUNCE_CYCLES+3 latency again.
